// File: rtl/divseq_pkg.sv
// divseq_pkg: shared definitions for the divisor sequencer.
//   - state encoding (IDLE, LOAD, RUN, DONE)
//   - default divisor/duration widths and smallest legal divisor
//   - table entry record (div, dur) at the default widths
package divseq_pkg;

    localparam int unsigned DIV_W_DEF   = 28;
    localparam int unsigned DUR_W_DEF   = 16;
    localparam int unsigned MIN_DIV_DEF = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] div;
        logic [DUR_W_DEF-1:0] dur;
    } divseq_entry_t;

endpackage

// File: rtl/divseq_period_timer.sv
// divseq_period_timer: mirrors the divider's output period and counts
// periods within the current table entry.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   div         - current divisor (>= 2)
//   dur         - current duration in output periods (0 treated as 1)
//   clear       - zero both counters at the next edge (has priority)
//   enable      - count this cycle
//   entry_last  - high on the final clk cycle of the entry
module divseq_period_timer
    import divseq_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF,
    parameter int unsigned DUR_W = DUR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic [DUR_W-1:0] dur,
    input  logic             clear,
    input  logic             enable,
    output logic             entry_last
);

    logic [DIV_W-1:0] period_cnt_q, period_cnt_d;
    logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
    logic             period_wrap;
    logic [DUR_W-1:0] dur_last;

    always_comb begin
        // div >= 2 is guaranteed upstream, so div-1 never underflows.
        period_wrap = (period_cnt_q == div - DIV_W'(1));
        // max(dur,1)-1
        dur_last    = (dur == '0) ? '0 : dur - DUR_W'(1);
        entry_last  = enable && period_wrap && (dur_cnt_q == dur_last);

        period_cnt_d = period_cnt_q;
        dur_cnt_d    = dur_cnt_q;
        if (clear) begin
            period_cnt_d = '0;
            dur_cnt_d    = '0;
        end else if (enable) begin
            if (period_wrap) begin
                period_cnt_d = '0;
                dur_cnt_d    = dur_cnt_q + DUR_W'(1);
            end else begin
                period_cnt_d = period_cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_q <= '0;
            dur_cnt_q    <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
            dur_cnt_q    <= dur_cnt_d;
        end
    end

endmodule

// File: rtl/divisor_sequencer.sv
// divisor_sequencer: plays a programmable table of (divisor, duration)
// entries into a clock divider's divisor input, with seamless entry
// transitions and optional looping.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   wr_en/wr_addr/wr_div/wr_dur - table write port (IDLE only)
//   seq_len, loop_en           - entries to play (1..DEPTH), loop enable
//   start, stop                - start request (IDLE), abort request
//   divisor, div_en            - divider control
//   busy, step_idx, done, err  - status
//   pass_cnt                   - completed passes (only with DIVSEQ_PASS_CNT_EN)
// Optional feature macro: DIVSEQ_PASS_CNT_EN
module divisor_sequencer
    import divseq_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned DUR_W   = DUR_W_DEF,
    parameter int unsigned MIN_DIV = MIN_DIV_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DIV_W-1:0]         wr_div,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic [$clog2(DEPTH):0]   seq_len,
    input  logic                     loop_en,
    input  logic                     start,
    input  logic                     stop,
    output logic [DIV_W-1:0]         divisor,
    output logic                     div_en,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     done,
    output logic                     err
`ifdef DIVSEQ_PASS_CNT_EN
    , output logic [15:0]            pass_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [DIV_W-1:0] MinDivV = DIV_W'(MIN_DIV);

    logic [DIV_W-1:0] tab_div_q [DEPTH];
    logic [DUR_W-1:0] tab_dur_q [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             div_en_q, div_en_d;
    logic [AW-1:0]    step_idx_q, step_idx_d;
    logic             err_q, err_d;

    logic             seq_valid;
    logic             is_last;
    logic [AW-1:0]    nxt_idx;
    logic [AW:0]      step_inc;
    logic             timer_clear;
    logic             entry_last;
    logic             pass_done;

    always_comb begin
        seq_valid = (seq_len != '0) && (seq_len <= (AW+1)'(DEPTH));
        step_inc  = {1'b0, step_idx_q} + (AW+1)'(1);
        // >= rather than == so a shrunken seq_len still terminates the pass.
        is_last   = (step_inc >= seq_len);
        nxt_idx   = is_last ? '0 : step_idx_q + AW'(1);
    end

    always_comb begin
        state_d     = state_q;
        divisor_d   = divisor_q;
        dur_d       = dur_q;
        div_en_d    = div_en_q;
        step_idx_d  = step_idx_q;
        err_d       = err_q;
        timer_clear = 1'b0;
        pass_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (seq_valid) begin
                        state_d    = ST_LOAD;
                        step_idx_d = '0;
                        err_d      = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    div_en_d = 1'b0;
                end else if (tab_div_q[step_idx_q] < MinDivV) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    divisor_d   = tab_div_q[step_idx_q];
                    dur_d       = tab_dur_q[step_idx_q];
                    div_en_d    = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    div_en_d = 1'b0;
                end else if (entry_last) begin
                    pass_done = is_last;
                    if (is_last && !loop_en) begin
                        state_d  = ST_DONE;
                        div_en_d = 1'b0;
                    end else if (tab_div_q[nxt_idx] < MinDivV) begin
                        state_d  = ST_IDLE;
                        div_en_d = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        // Seamless hand-over: new divisor lands on the same
                        // edge the old entry's last period ends.
                        step_idx_d  = nxt_idx;
                        divisor_d   = tab_div_q[nxt_idx];
                        dur_d       = tab_dur_q[nxt_idx];
                        timer_clear = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                div_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            divisor_q  <= MinDivV;
            dur_q      <= '0;
            div_en_q   <= 1'b0;
            step_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            divisor_q  <= divisor_d;
            dur_q      <= dur_d;
            div_en_q   <= div_en_d;
            step_idx_q <= step_idx_d;
            err_q      <= err_d;
        end
    end

    // Table storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            tab_div_q[wr_addr] <= wr_div;
            tab_dur_q[wr_addr] <= wr_dur;
        end
    end

    divseq_period_timer #(
        .DIV_W (DIV_W),
        .DUR_W (DUR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .div        (divisor_q),
        .dur        (dur_q),
        .clear      (timer_clear),
        .enable     (state_q == ST_RUN),
        .entry_last (entry_last)
    );

`ifdef DIVSEQ_PASS_CNT_EN
    logic [15:0] pass_cnt_q, pass_cnt_d;

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        if (state_q == ST_IDLE && start && !stop && seq_valid) begin
            pass_cnt_d = '0;
        end else if (pass_done && (pass_cnt_q != 16'hFFFF)) begin
            pass_cnt_d = pass_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pass_cnt_q <= '0;
        else        pass_cnt_q <= pass_cnt_d;
    end

    assign pass_cnt = pass_cnt_q;
`else
    // Pass tracking absent in this build.
    logic unused_pass_done;
    assign unused_pass_done = pass_done;
`endif

    assign divisor  = divisor_q;
    assign div_en   = div_en_q;
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign step_idx = step_idx_q;
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_divisor_sequencer.sv
// Self-checking bench for divisor_sequencer: directed scenarios plus
// randomized tables, checked against a per-cycle expected divisor trace
// built from the table contents.
module tb_divisor_sequencer;

    localparam int DEPTH   = 8;
    localparam int DIV_W   = 28;
    localparam int DUR_W   = 16;
    localparam int MIN_DIV = 2;
    localparam int AW      = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [DIV_W-1:0] wr_div = '0;
    logic [DUR_W-1:0] wr_dur = '0;
    logic [AW:0]      seq_len = '0;
    logic             loop_en = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [DIV_W-1:0] divisor;
    logic             div_en;
    logic             busy;
    logic [AW-1:0]    step_idx;
    logic             done;
    logic             err;
`ifdef DIVSEQ_PASS_CNT_EN
    logic [15:0]      pass_cnt;
`endif

    divisor_sequencer #(
        .DEPTH   (DEPTH),
        .DIV_W   (DIV_W),
        .DUR_W   (DUR_W),
        .MIN_DIV (MIN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_div   (wr_div),
        .wr_dur   (wr_dur),
        .seq_len  (seq_len),
        .loop_en  (loop_en),
        .start    (start),
        .stop     (stop),
        .divisor  (divisor),
        .div_en   (div_en),
        .busy     (busy),
        .step_idx (step_idx),
        .done     (done),
        .err      (err)
`ifdef DIVSEQ_PASS_CNT_EN
        , .pass_cnt (pass_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int unsigned m_div [DEPTH];
    int unsigned m_dur [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int unsigned d, input int unsigned u, input bit upd);
        wr_en = 1'b1; wr_addr = AW'(a); wr_div = DIV_W'(d); wr_dur = DUR_W'(u);
        tick();
        wr_en = 1'b0;
        if (upd) begin
            m_div[a] = d;
            m_dur[a] = u;
        end
    endtask

    // Build the expected divisor trace from the table, then start the DUT
    // and compare cycle by cycle. Ends by completion, bad entry or stop.
    task automatic play(input int len, input bit lp, input int max_cyc);
        int unsigned q_div[$];
        int          q_idx[$];
        int          ends[$];
        bit          bad = 0;
        bit          finished = 0;
        bit          stop_path;
        int          idx = 0;
        int          n;
        int          lim;
        int          exp_pass = 0;
        int unsigned last_div;
        while (q_div.size() < max_cyc) begin
            if (m_div[idx] < MIN_DIV) begin bad = 1; break; end
            repeat (m_div[idx] * ((m_dur[idx] == 0) ? 1 : m_dur[idx])) begin
                q_div.push_back(m_div[idx]);
                q_idx.push_back(idx);
            end
            idx++;
            if (idx == len) begin
                ends.push_back(q_div.size());
                if (!lp) begin finished = 1; break; end
                idx = 0;
            end
        end
        n = (q_div.size() < max_cyc) ? q_div.size() : max_cyc;
        stop_path = !bad && !(finished && q_div.size() <= max_cyc);

        start = 1'b1; seq_len = (AW+1)'(len); loop_en = lp;
        tick();
        start = 1'b0;
        check("load", {busy, div_en, err, done}, 4'b1000);
        for (int i = 0; i < n; i++) begin
            tick();
            check("run", {div_en, busy, done, err, AW'(q_idx[i]), DIV_W'(q_div[i])},
                  {1'b1, 1'b1, 1'b0, 1'b0, AW'(q_idx[i]), DIV_W'(q_div[i])});
        end
        last_div = (n > 0) ? q_div[n-1] : MIN_DIV;
        if (bad) begin
            tick();
            check("bad_entry", {err, div_en, busy, done}, 4'b1000);
        end else if (!stop_path) begin
            tick();
            check("done", {done, busy, div_en, divisor}, {3'b100, DIV_W'(last_div)});
        end else begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check("stopped", {div_en, busy, done, divisor}, {3'b000, DIV_W'(last_div)});
        end
        lim = stop_path ? n - 1 : n;
        foreach (ends[k]) if (ends[k] <= lim) exp_pass++;
`ifdef DIVSEQ_PASS_CNT_EN
        check("pass_cnt", pass_cnt, 64'(exp_pass));
`else
        if (exp_pass < 0) $display("unreachable");
`endif
        tick();
        check("idle_after", {done, busy, div_en}, 3'b000);
    endtask

    initial begin
        tick();
        tick();
        check("rst_divisor", divisor, 64'(MIN_DIV));
        check("rst_flags", {div_en, busy, done, err, step_idx}, '0);
        rst_n = 1'b1;
        tick();

        // Basic two-entry run, then looping for 40 cycles.
        wr(0, 4, 2, 1);
        wr(1, 6, 1, 1);
        play(2, 0, 1000);
        play(2, 1, 40);

        // Illegal divisor in entry 1; next valid start clears err.
        wr(1, 1, 1, 1);
        play(2, 0, 1000);
        check("err_sticky", err, 1);
        wr(1, 6, 1, 1);
        play(2, 0, 1000);

        // Stop on the third RUN cycle.
        play(2, 0, 3);

        // start and stop together in IDLE.
        start = 1'b1; stop = 1'b1; seq_len = 2;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop", {busy, div_en, done}, 3'b000);
        tick();
        check("start_stop2", busy, 0);

        // Write while busy is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        wr(0, 9, 5, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        play(2, 0, 1000);

        // dur=0 holds exactly one period.
        wr(0, 3, 0, 1);
        play(1, 0, 1000);
        wr(0, 4, 2, 1);

        // Async reset mid-run.
        start = 1'b1; seq_len = 2; loop_en = 0;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {divisor, div_en, busy}, {DIV_W'(MIN_DIV), 2'b00});
        tick();
        rst_n = 1'b1;
        tick();

        // Illegal seq_len values.
        start = 1'b1; seq_len = 0;
        tick();
        start = 1'b0;
        check("len0_err", {err, busy}, 2'b10);
        tick();
        check("len0_idle", busy, 0);
        start = 1'b1; seq_len = 9;
        tick();
        start = 1'b0;
        check("len9", {err, busy}, 2'b10);
        tick();

        // Randomized tables.
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int unsigned d;
                d = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 6);
                wr(a, d, $urandom_range(0, 3), 1);
            end
            play($urandom_range(1, DEPTH), 1'($urandom_range(0, 1)), $urandom_range(5, 60));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
